freelist_allocator: RTL

FREELIST_ALLOCATOR -- requirements
Module: freelist_allocator

---
 rtl/freelist_allocator_pkg.sv | 27 ++
 rtl/freelist_psel.sv | 31 +++
 rtl/sys_defs.svh | 14 +
 rtl/freelist_allocator.sv | 82 ++++++++
 4 files changed

// File: rtl/freelist_allocator_pkg.sv
// Constants and helpers for the free-list allocator, derived from sys_defs.svh.
// No ports; provides lane/register sizes, counter width, reset free vector and
// a popcount helper.
`include "sys_defs.svh"

package freelist_allocator_pkg;

  localparam int unsigned NumLanes = `N;
  localparam int unsigned NumPhys  = `PHYS_REG_SZ_R10K;
  localparam int unsigned NumArch  = `ARCH_REG_SZ;
  localparam int unsigned TagW     = `PHYS_TAG;
  // Must hold NumPhys itself, hence the +1.
  localparam int unsigned CntW     = $clog2(NumPhys + 1);

  // Registers holding the initial architectural mappings are busy after reset.
  localparam logic [NumPhys-1:0] ResetFree = {{(NumPhys - NumArch){1'b1}}, {NumArch{1'b0}}};

  function automatic logic [CntW-1:0] popcount(input logic [NumPhys-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < NumPhys; i++) begin
      cnt = cnt + CntW'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/freelist_psel.sv
// Lowest-index free register selector.
//   free_vec_i : free register vector (1 = free)
//   req_i      : per-lane request mask, lane 0 oldest
//   grant_o    : per-lane one-hot grant, all-zero when not requesting or exhausted
// Each requesting lane takes the lowest remaining free bit, so lane k gets the
// (m+1)-th lowest free register where m counts requesting lanes below k.
`include "sys_defs.svh"

module freelist_psel
  import freelist_allocator_pkg::*;
(
  input  logic [NumPhys-1:0]               free_vec_i,
  input  logic [NumLanes-1:0]              req_i,
  output logic [NumLanes-1:0][NumPhys-1:0] grant_o
);

  logic [NumPhys-1:0] avail;

  always_comb begin
    avail   = free_vec_i;
    grant_o = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (req_i[k]) begin
        // Isolate lowest set bit; zero when nothing is left.
        grant_o[k] = avail & (~avail + NumPhys'(1));
        avail      = avail & ~grant_o[k];
      end
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared machine-size definitions for the rename/freelist slice.
//   `N                : dispatch/retire width (lanes)
//   `PHYS_REG_SZ_R10K : number of physical registers
//   `ARCH_REG_SZ      : number of architectural registers
//   `PHYS_TAG         : bit width of a physical register tag
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define N                3
`define PHYS_REG_SZ_R10K 64
`define ARCH_REG_SZ      32
`define PHYS_TAG         $clog2(`PHYS_REG_SZ_R10K)

`endif

// File: rtl/freelist_allocator.sv
// Physical register free list with speculative and architectural views.
//   clock               : system clock, rising edge
//   reset               : asynchronous active-low reset
//   alloc_req           : per-lane allocation request, lane 0 oldest
//   granted_regs        : per-lane one-hot grant (combinational from registered state)
//   freelist_free_slots : popcount of the speculative free vector
//   retire_valid        : per-lane retire strobe
//   retire_phys_rd      : retiring new mapping (becomes architecturally busy)
//   retire_told         : retiring old mapping (freed)
//   flush               : recovery; speculative view reloads from architectural view
//   double_free         : registered pulse when a freed tag was already free
`include "sys_defs.svh"

module freelist_allocator
  import freelist_allocator_pkg::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NumLanes-1:0]              alloc_req,
  output logic [NumLanes-1:0][NumPhys-1:0] granted_regs,
  output logic [CntW-1:0]                  freelist_free_slots,
  input  logic [NumLanes-1:0]              retire_valid,
  input  logic [NumLanes-1:0][TagW-1:0]    retire_phys_rd,
  input  logic [NumLanes-1:0][TagW-1:0]    retire_told,
  input  logic                             flush,
  output logic                             double_free
);

  logic [NumPhys-1:0] spec_free_q, spec_free_d;
  logic [NumPhys-1:0] arch_free_q, arch_free_d;
  logic               double_free_q, double_free_d;

  // Grants see only registered state, so same-cycle frees are never bypassed.
  freelist_psel u_psel (
    .free_vec_i (spec_free_q),
    .req_i      (alloc_req),
    .grant_o    (granted_regs)
  );

  always_comb begin
    spec_free_d   = spec_free_q;
    arch_free_d   = arch_free_q;
    double_free_d = 1'b0;

    for (int unsigned k = 0; k < NumLanes; k++) begin
      spec_free_d = spec_free_d & ~granted_regs[k];
    end

    // Lanes applied in age order so a younger lane's update wins on overlap.
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (retire_valid[k]) begin
        if (spec_free_q[retire_told[k]]) begin
          double_free_d = 1'b1;
        end
        spec_free_d[retire_told[k]]    = 1'b1;
        arch_free_d[retire_phys_rd[k]] = 1'b0;
        arch_free_d[retire_told[k]]    = 1'b1;
      end
    end

    // Recovery drops this cycle's grants and adopts the committed view.
    if (flush) begin
      spec_free_d = arch_free_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      spec_free_q   <= ResetFree;
      arch_free_q   <= ResetFree;
      double_free_q <= 1'b0;
    end else begin
      spec_free_q   <= spec_free_d;
      arch_free_q   <= arch_free_d;
      double_free_q <= double_free_d;
    end
  end

  assign freelist_free_slots = popcount(spec_free_q);
  assign double_free         = double_free_q;

endmodule
